// File: rtl/corrector_sequencer.sv
// corrector_sequencer
//   Controller for an M-bit non-linear corrector core. Takes raw samples,
//   hands each one to the core along with a fresh LFSR selector, and runs the
//   core's start/done handshake. PACK results are packed into one output word.
//
// Ports
//   clk, rst        rising-edge clock; synchronous active-low reset
//   enable          run request
//   raw_data/valid  raw sample in; raw_ready is the sequencer's accept
//   core_in/lfsr    sample and selector to the core, held from accept to done
//   core_start      one-cycle start pulse to the core
//   core_done/result single-cycle result from the core
//   out_data/valid  packed word out; out_ready is the consumer's accept
//   busy            high whenever the FSM is not IDLE
//   timeout_err     sticky core-timeout flag, cleared only by reset
//   state_dbg       current FSM state encoding, for checkers
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The valid side holds its data stable until that edge. raw_ready
// and out_valid are registered and depend only on the FSM state.
module corrector_sequencer #(
    parameter int                  M_WIDTH     = 3,
    parameter int                  INPUT_WIDTH = 10,
    parameter int                  PACK        = 4,
    parameter logic [M_WIDTH-1:0]  LFSR_TAPS   = 3'b110,
    parameter logic [M_WIDTH-1:0]  LFSR_SEED   = 3'b001,
    parameter int                  TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [INPUT_WIDTH-1:0]    raw_data,
    input  logic                      raw_valid,
    output logic                      raw_ready,
    output logic [INPUT_WIDTH-1:0]    core_in,
    output logic [M_WIDTH-1:0]        core_lfsr,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [M_WIDTH-1:0]        core_result,
    output logic [M_WIDTH*PACK-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [2:0]                state_dbg
);

    localparam int SLOT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [M_WIDTH-1:0] LFSR_INIT = (LFSR_SEED == '0) ? M_WIDTH'(1) : LFSR_SEED;
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(PACK - 1);
    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RAW  = 3'd1,
        ISSUE     = 3'd2,
        WAIT_CORE = 3'd3,
        PUSH      = 3'd4,
        ERR       = 3'd5
    } state_t;

    // Galois right-shift step: the bit shifted out selects the tap mask.
    function automatic logic [M_WIDTH-1:0] lfsr_step(input logic [M_WIDTH-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    state_t                    state_q, state_d;
    logic [SLOT_W-1:0]         slot_q, slot_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [M_WIDTH-1:0]        lfsr_q, lfsr_d;
    logic [M_WIDTH*PACK-1:0]   pack_q, pack_d;
    logic [INPUT_WIDTH-1:0]    core_in_q, core_in_d;
    logic [M_WIDTH-1:0]        core_lfsr_q, core_lfsr_d;
    logic                      raw_ready_q, raw_ready_d;
    logic                      core_start_q, core_start_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      timeout_err_q, timeout_err_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        timer_d     = timer_q;
        lfsr_d      = lfsr_q;
        pack_d      = pack_q;
        core_in_d   = core_in_q;
        core_lfsr_d = core_lfsr_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_RAW;
            end
            WAIT_RAW: begin
                // An offered sample wins over a drop of enable; the partial
                // word is kept either way.
                if (raw_valid && raw_ready_q) begin
                    core_in_d   = raw_data;
                    core_lfsr_d = lfsr_q;
                    state_d     = ISSUE;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                timer_d = timer_q + 1'b1;
                // A done arriving on the last timer tick still counts.
                if (core_done) begin
                    pack_d[int'(slot_q) * M_WIDTH +: M_WIDTH] = core_result;
                    lfsr_d = lfsr_step(lfsr_q);
                    if (slot_q == LAST_SLOT) begin
                        state_d = PUSH;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = WAIT_RAW;
                    end
                end else if (timer_q == LAST_TICK) begin
                    state_d = ERR;
                end
            end
            PUSH: begin
                if (out_ready) begin
                    slot_d  = '0;
                    pack_d  = '0;
                    state_d = enable ? WAIT_RAW : IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        raw_ready_d   = (state_d == WAIT_RAW);
        core_start_d  = (state_d == ISSUE);
        out_valid_d   = (state_d == PUSH);
        busy_d        = (state_d != IDLE);
        timeout_err_d = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            timer_q       <= '0;
            lfsr_q        <= LFSR_INIT;
            pack_q        <= '0;
            core_in_q     <= '0;
            core_lfsr_q   <= '0;
            raw_ready_q   <= 1'b0;
            core_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            timer_q       <= timer_d;
            lfsr_q        <= lfsr_d;
            pack_q        <= pack_d;
            core_in_q     <= core_in_d;
            core_lfsr_q   <= core_lfsr_d;
            raw_ready_q   <= raw_ready_d;
            core_start_q  <= core_start_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign raw_ready   = raw_ready_q;
    assign core_in     = core_in_q;
    assign core_lfsr   = core_lfsr_q;
    assign core_start  = core_start_q;
    assign out_data    = pack_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_corrector_sequencer.sv
// Directed testbench for corrector_sequencer (M=3, PACK=4, TIMEOUT=16, seed 001).
// A behavioural core answers each start with a done two cycles later, taking
// results from a queue the test fills. Outputs are sampled on falling edges.
module tb_corrector_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [9:0]  raw_data;
    logic        raw_valid;
    logic        raw_ready;
    logic [9:0]  core_in;
    logic [2:0]  core_lfsr;
    logic        core_start;
    logic        core_done;
    logic [2:0]  core_result;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    logic        model_en;
    logic        model_done;
    logic [2:0]  model_result;
    logic        spur_done;
    logic [2:0]  spur_result;
    logic [2:0]  res_q[$];
    logic [2:0]  lfsr_seen_q[$];
    logic [2:0]  exp_q[$];

    int n_checks;
    int n_fail;

    assign core_done   = model_done | spur_done;
    assign core_result = model_result | spur_result;

    corrector_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .raw_data    (raw_data),
        .raw_valid   (raw_valid),
        .raw_ready   (raw_ready),
        .core_in     (core_in),
        .core_lfsr   (core_lfsr),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- core model ----------------
    initial begin
        model_done   = 1'b0;
        model_result = 3'd0;
        forever begin
            @(negedge clk);
            if (model_en && core_start) begin
                lfsr_seen_q.push_back(core_lfsr);
                @(negedge clk);
                @(negedge clk);
                model_done   = 1'b1;
                model_result = (res_q.size() > 0) ? res_q.pop_front() : 3'd0;
                @(negedge clk);
                model_done   = 1'b0;
                model_result = 3'd0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every selector the core saw against the expected queue.
    task automatic check_lfsr_seq(input string tag);
        while (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            if (lfsr_seen_q.size() == 0) check(tag, 32'hdead, {29'd0, e});
            else check(tag, {29'd0, lfsr_seen_q.pop_front()}, {29'd0, e});
        end
        check({tag, "_extra"}, lfsr_seen_q.size(), 0);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        enable    = 1'b0;
        raw_valid = 1'b0;
        out_ready = 1'b0;
        spur_done = 1'b0;
        spur_result = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        res_q.delete();
        lfsr_seen_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_raw_ready"}, raw_ready, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_lfsr"}, core_lfsr, 0);
    endtask

    // Offer one sample; returns on the falling edge after the accept edge.
    task automatic send(input logic [9:0] d);
        int n;
        n = 0;
        @(negedge clk);
        raw_data  = d;
        raw_valid = 1'b1;
        while (!raw_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!raw_ready) begin
            check("accept_wait", 0, 1);
            raw_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 raw_valid = 1'b0;
            @(negedge clk);
            check("start_latency", core_start, 1);
            check("core_in_hold", core_in, d);
        end
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid_wait", 0, 1);
    endtask

    task automatic release_word();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        enable    = 1'b0;
        raw_data  = '0;
        raw_valid = 1'b0;
        out_ready = 1'b0;
        model_en  = 1'b1;
        spur_done = 1'b0;
        spur_result = 3'd0;

        // Reset state, and IDLE holds without enable.
        do_reset();
        check_reset_state("reset");
        repeat (3) @(negedge clk);
        check("idle_no_enable_busy", busy, 0);

        // 1: basic word, latency, LFSR start values. 3: backpressure.
        enable = 1'b1;
        res_q = '{3'b101, 3'b010, 3'b111, 3'b001};
        send(10'h0a1);
        send(10'h155);
        send(10'h2aa);
        send(10'h3ff);
        @(negedge clk);
        check("push_latency_d1", out_valid, 0);
        @(negedge clk);
        check("push_latency_d2", out_valid, 0);
        @(negedge clk);
        check("push_latency_d3", out_valid, 1);
        check("basic_word", out_data, 12'h3d5);
        exp_q = '{3'b001, 3'b110, 3'b011, 3'b111};
        check_lfsr_seq("basic_lfsr");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 12'h3d5);
            check("bp_raw_ready", raw_ready, 0);
        end
        release_word();
        @(negedge clk);
        check("after_pop_out_valid", out_valid, 0);
        check("after_pop_out_data", out_data, 0);
        check("after_pop_raw_ready", raw_ready, 1);

        // 2: full LFSR period over two words.
        do_reset();
        enable = 1'b1;
        res_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 4; i++) send(10'(i + 16));
        wait_out();
        check("lfsr_word0", out_data, 12'h688);
        release_word();
        for (int i = 0; i < 4; i++) send(10'(i + 32));
        wait_out();
        check("lfsr_word1", out_data, 12'hfac);
        release_word();
        exp_q = '{3'b001, 3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};
        check_lfsr_seq("lfsr_seq");

        // 4: core never answers -> sticky timeout.
        do_reset();
        model_en = 1'b0;
        enable   = 1'b1;
        send(10'h123);
        repeat (16) @(negedge clk);
        check("timeout_not_early", timeout_err, 0);
        @(negedge clk);
        check("timeout_set", timeout_err, 1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("timeout_sticky", timeout_err, 1);
            check("err_raw_ready", raw_ready, 0);
            check("err_core_start", core_start, 0);
            check("err_busy", busy, 1);
        end
        do_reset();
        model_en = 1'b1;
        check("timeout_cleared", timeout_err, 0);

        // 5: reset after two results drops the partial word.
        enable = 1'b1;
        res_q = '{3'd5, 3'd6};
        send(10'h011);
        send(10'h022);
        repeat (4) @(negedge clk);
        do_reset();
        check_reset_state("mid_reset");
        enable = 1'b1;
        res_q = '{3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 4; i++) send(10'(i + 64));
        wait_out();
        check("after_reset_word", out_data, 12'h8d1);
        exp_q = '{3'b001, 3'b110, 3'b011, 3'b111};
        check_lfsr_seq("after_reset_lfsr");
        release_word();

        // 6: spurious done ignored; enable drop in WAIT_RAW keeps partial word.
        do_reset();
        enable = 1'b1;
        res_q = '{3'd6, 3'd5};
        send(10'h0f0);
        send(10'h00f);
        repeat (4) @(negedge clk);
        spur_result = 3'd7;
        spur_done   = 1'b1;
        @(negedge clk);
        spur_done   = 1'b0;
        spur_result = 3'd0;
        check("spur_raw_ready", raw_ready, 1);
        check("spur_busy", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        check("drop_enable_busy", busy, 0);
        check("drop_enable_raw_ready", raw_ready, 0);
        enable = 1'b1;
        res_q = '{3'd3, 3'd1};
        send(10'h1a0);
        send(10'h1b0);
        wait_out();
        check("partial_kept_word", out_data, 12'h2ee);
        exp_q = '{3'b001, 3'b110, 3'b011, 3'b111};
        check_lfsr_seq("spur_lfsr");
        release_word();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
